// File: rtl/clock_cascade_ctrl.sv
// Time-of-day controller: seconds/minutes/hours cascade driven by a tick enable,
// with a set-mode FSM for adjusting hours and minutes from button pulses.
module clock_cascade_ctrl #(
   parameter int unsigned SEC_MAX = 59,
   parameter int unsigned MIN_MAX = 59,
   parameter int unsigned HR_MAX  = 23
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hr,
   output logic [1:0] mode,
   output logic       day_wrap
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      BAD     = 2'd3
   } state_e;

   localparam logic [5:0] SEC_TC = 6'(SEC_MAX);
   localparam logic [5:0] MIN_TC = 6'(MIN_MAX);
   localparam logic [4:0] HR_TC  = 5'(HR_MAX);

   state_e     state_q, state_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hr_q, hr_d;
   logic       wrap_q, wrap_d;

   logic sec_tc, min_tc, hr_tc;

   assign sec_tc = (sec_q == SEC_TC);
   assign min_tc = (min_q == MIN_TC);
   assign hr_tc  = (hr_q == HR_TC);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
         sec_q   <= '0;
         min_q   <= '0;
         hr_q    <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hr_q    <= hr_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hr_d    = hr_q;
      wrap_d  = 1'b0;
      case (state_q)
         RUN: begin
            // tick and btn_mode may coincide: the count still lands on this edge
            if (tick) begin
               if (sec_tc) begin
                  sec_d = '0;
                  if (min_tc) begin
                     min_d = '0;
                     if (hr_tc) begin
                        hr_d   = '0;
                        wrap_d = 1'b1;
                     end else begin
                        hr_d = hr_q + 5'd1;
                     end
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
            if (btn_mode) state_d = SET_HR;
         end
         SET_HR: begin
            if (btn_mode)     state_d = SET_MIN;
            else if (btn_inc) hr_d = hr_tc ? '0 : hr_q + 5'd1;
         end
         SET_MIN: begin
            if (btn_mode) begin
               state_d = RUN;
               sec_d   = '0;
            end else if (btn_inc) begin
               min_d = min_tc ? '0 : min_q + 6'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   assign sec      = sec_q;
   assign min      = min_q;
   assign hr       = hr_q;
   assign mode     = state_q;
   assign day_wrap = wrap_q;

endmodule

// File: tb/tb_clock_cascade_ctrl.sv
// Directed bench for clock_cascade_ctrl with hand-computed expected values.
module tb_clock_cascade_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       tick = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hr;
   logic [1:0] mode;
   logic       day_wrap;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   clock_cascade_ctrl #(.SEC_MAX(59), .MIN_MAX(59), .HR_MAX(23)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .tick     (tick),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .sec      (sec),
      .min      (min),
      .hr       (hr),
      .mode     (mode),
      .day_wrap (day_wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s);
      chk({tag, ".hr"}, 32'(hr), 32'(h));
      chk({tag, ".min"}, 32'(min), 32'(m));
      chk({tag, ".sec"}, 32'(sec), 32'(s));
   endtask

   task automatic step(input logic t, input logic m, input logic i);
      @(negedge clk);
      tick = t;
      btn_mode = m;
      btn_inc = i;
      @(posedge clk);
      #1;
      tick = 1'b0;
      btn_mode = 1'b0;
      btn_inc = 1'b0;
   endtask

   initial begin
      // reset
      repeat (3) @(posedge clk);
      #1;
      chk_time("reset", 0, 0, 0);
      chk("reset.mode", 32'(mode), 0);
      chk("reset.wrap", 32'(day_wrap), 0);
      @(negedge clk);
      rstn = 1'b1;

      // seconds into minutes
      repeat (59) step(1'b1, 1'b0, 1'b0);
      chk_time("t59", 0, 0, 59);
      step(1'b1, 1'b0, 1'b0);
      chk_time("t60", 0, 1, 0);
      chk("t60.wrap", 32'(day_wrap), 0);
      step(1'b0, 1'b0, 1'b1);
      chk_time("run_inc_ignored", 0, 1, 0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      chk("sec5", 32'(sec), 5);
      step(1'b1, 1'b1, 1'b0);
      chk("tick_mode.sec", 32'(sec), 6);
      chk("tick_mode.mode", 32'(mode), 1);

      // SET_HR: hours wrap, ticks frozen
      for (int k = 0; k < 24; k++) step(k[0], 1'b0, 1'b1);
      chk("sethr24.hr", 32'(hr), 0);
      chk("sethr24.wrap", 32'(day_wrap), 0);
      step(1'b1, 1'b0, 1'b1);
      chk_time("sethr25", 1, 1, 6);
      chk("sethr25.wrap", 32'(day_wrap), 0);
      chk("sethr25.mode", 32'(mode), 1);
      step(1'b0, 1'b1, 1'b1);
      chk("mode_inc.mode", 32'(mode), 2);
      chk("mode_inc.hr", 32'(hr), 1);

      // SET_MIN: minute wrap without carry
      repeat (58) step(1'b0, 1'b0, 1'b1);
      chk("setmin59", 32'(min), 59);
      step(1'b1, 1'b0, 1'b1);
      chk_time("setmin_wrap", 1, 0, 6);
      chk("setmin_wrap.wrap", 32'(day_wrap), 0);
      repeat (59) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk("exit_set.mode", 32'(mode), 0);
      chk_time("exit_set", 1, 59, 0);

      // load 23:59
      step(1'b0, 1'b1, 1'b0);
      repeat (22) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk_time("load", 23, 59, 0);
      chk("load.mode", 32'(mode), 0);

      // day rollover
      repeat (59) step(1'b1, 1'b0, 1'b0);
      chk_time("pre_wrap", 23, 59, 59);
      chk("pre_wrap.wrap", 32'(day_wrap), 0);
      step(1'b1, 1'b0, 1'b0);
      chk_time("wrap", 0, 0, 0);
      chk("wrap.wrap", 32'(day_wrap), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("post_wrap.wrap", 32'(day_wrap), 0);
      chk_time("post_wrap", 0, 0, 0);
      step(1'b1, 1'b0, 1'b0);
      chk("post_wrap2.sec", 32'(sec), 1);
      chk("post_wrap2.wrap", 32'(day_wrap), 0);

      // async reset during SET_MIN at 12:34
      step(1'b0, 1'b1, 1'b0);
      repeat (12) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      repeat (34) step(1'b0, 1'b0, 1'b1);
      chk_time("pre_rst", 12, 34, 1);
      chk("pre_rst.mode", 32'(mode), 2);
      #2;
      rstn = 1'b0;
      #1;
      chk_time("async_rst", 0, 0, 0);
      chk("async_rst.mode", 32'(mode), 0);
      @(negedge clk);
      rstn = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      chk_time("after_rst", 0, 0, 1);
      chk("after_rst.mode", 32'(mode), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
